// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the internal Bus arbiter: word width, FSM states
// and the fixed requester slots on the processor Bus.
package bus_arbiter_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_TURN  = 2'd2
    } arbState_t;

    localparam int BUSREQ_PC  = 0;
    localparam int BUSREQ_IR  = 1;
    localparam int BUSREQ_Z   = 2;
    localparam int BUSREQ_MEM = 3;

    // Width of a counter that must reach maxHold; never narrower than one bit
    function automatic int holdWidth(input int maxHold);
        return (maxHold < 1) ? 1 : $clog2(maxHold + 1);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first requester at or after the
// pointer, wrapping to the lowest index when nothing at or above it requests.
module bus_arbiter_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 3
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Two descending scans so the lowest qualifying index wins; the second
    // scan only covers indices at/after the pointer and overrides the wrap pick
    always_comb begin
        o_found = |i_req;
        o_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i] && (IDX_W'(i) >= i_ptr)) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the internal Bus: one registered one-hot grant,
// bounded hold with preemption, and a dead cycle between different owners.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = WORD_W,
    parameter int MAX_HOLD = 4,
    parameter int IDX_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       grant,
    output logic [IDX_W-1:0]      owner,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic                  preempt
);

    localparam int                HOLD_W   = holdWidth(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NREQ - 1);

    arbState_t         r_state;
    logic [NREQ-1:0]   r_grant;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_rrPtr;
    logic [HOLD_W-1:0] r_holdCnt;
    logic              r_preempt;

    logic              w_found;
    logic [IDX_W-1:0]  w_winIdx;
    logic [NREQ-1:0]   w_winOnehot;
    logic [IDX_W-1:0]  w_ownerNext;
    logic              w_ownerReq;
    logic              w_othersReq;
    logic              w_holdSat;
    logic              w_holdExpired;

    bus_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rrPick (
        .i_req   (req),
        .i_ptr   (r_rrPtr),
        .o_found (w_found),
        .o_idx   (w_winIdx)
    );

    assign w_winOnehot   = NREQ'(1) << w_winIdx;
    assign w_ownerNext   = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
    // The grant is one-hot on the owner, so masking req with it isolates the owner's request
    assign w_ownerReq    = |(req & r_grant);
    assign w_othersReq   = |(req & ~r_grant);
    assign w_holdSat     = (MAX_HOLD == 0) || (r_holdCnt == HOLD_MAX);
    assign w_holdExpired = (MAX_HOLD != 0) && (r_holdCnt == HOLD_MAX);

    // Arbitration FSM: grant on entry to GRANT, release/preempt through TURN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_rrPtr   <= '0;
            r_holdCnt <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                ARB_IDLE, ARB_TURN: begin
                    if (w_found) begin
                        r_state   <= ARB_GRANT;
                        r_grant   <= w_winOnehot;
                        r_owner   <= w_winIdx;
                        r_holdCnt <= HOLD_ONE;
                    end else begin
                        r_state <= ARB_IDLE;
                        r_grant <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (!w_ownerReq) begin
                        r_state <= ARB_TURN;
                        r_grant <= '0;
                        r_rrPtr <= w_ownerNext;
                    end else if (w_holdExpired && w_othersReq) begin
                        r_state   <= ARB_TURN;
                        r_grant   <= '0;
                        r_rrPtr   <= w_ownerNext;
                        r_preempt <= 1'b1;
                    end else if (!w_holdSat) begin
                        r_holdCnt <= r_holdCnt + HOLD_ONE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Bus data mux: AND-OR of the granted slice, zero when nobody owns the Bus
    always_comb begin
        bus_out = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                bus_out = bus_out | data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign grant     = r_grant;
    assign owner     = r_owner;
    assign bus_valid = |r_grant;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed request patterns, a behavioural ownership
// model compared every cycle, and hand-computed checkpoints.
module tb_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 16;
    localparam int MAX_HOLD = 4;
    localparam int IDX_W    = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       grant;
    logic [IDX_W-1:0]      owner;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic                  preempt;

    logic [WIDTH-1:0] dataWord [NREQ];

    int vecCount = 0;
    int errCount = 0;

    // Model of who owns the Bus: -1 means nobody (idle or turnaround)
    int mOwner = -1;
    int mPtr   = 0;
    int mHold  = 0;
    bit mPre   = 1'b0;
    int mWin;
    bit mOthers;

    bus_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD),
        .IDX_W    (IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .owner     (owner),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    // Pack the per-requester words onto the flat data bus
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_in[i*WIDTH +: WIDTH] = dataWord[i];
        end
    end

    // Round-robin choice: first requester counting upward from ptr, modulo NREQ
    function automatic int pickWinner(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit otherPending(input logic [NREQ-1:0] r, input int who);
        for (int i = 0; i < NREQ; i++) begin
            if (i != who && r[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    always_comb mWin    = pickWinner(req, mPtr);
    always_comb mOthers = otherPending(req, mOwner);

    // Ownership rules applied once per clock edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mOwner <= -1;
            mPtr   <= 0;
            mHold  <= 0;
            mPre   <= 1'b0;
        end else begin
            mPre <= 1'b0;
            if (mOwner < 0) begin
                mOwner <= mWin;
                mHold  <= 1;
            end else if (!req[mOwner]) begin
                mOwner <= -1;
                mPtr   <= (mOwner + 1) % NREQ;
            end else if (MAX_HOLD != 0 && mHold >= MAX_HOLD && mOthers) begin
                mOwner <= -1;
                mPtr   <= (mOwner + 1) % NREQ;
                mPre   <= 1'b1;
            end else if (mHold < MAX_HOLD) begin
                mHold <= mHold + 1;
            end
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    task automatic checkOutput();
        logic [NREQ-1:0]  expGrant;
        logic [WIDTH-1:0] expBus;
        expGrant = '0;
        expBus   = '0;
        if (mOwner >= 0) begin
            expGrant[mOwner] = 1'b1;
            expBus = dataWord[mOwner];
        end
        checkVal("grant", 32'(grant), 32'(expGrant));
        checkVal("bus_valid", 32'(bus_valid), 32'(mOwner >= 0));
        checkVal("bus_out", 32'(bus_out), 32'(expBus));
        checkVal("preempt", 32'(preempt), 32'(mPre));
        checkVal("grantOnehot0", 32'($onehot0(grant)), 32'd1);
        if (mOwner >= 0) checkVal("owner", 32'(owner), 32'(mOwner));
    endtask

    always @(negedge clk) checkOutput();

    task automatic applyStimulus(input logic [NREQ-1:0] r);
        req = r;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic resetPulse();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    logic [NREQ-1:0] rrSeq   [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NREQ-1:0] preGrant[11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                                      4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    logic            prePulse[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        reset = 1'b1;
        req   = '0;
        dataWord[0] = 16'hBEEF;
        dataWord[1] = 16'h1234;
        dataWord[2] = 16'hCAFE;
        dataWord[3] = 16'h5A5A;
        #12;
        checkVal("rstGrant", 32'(grant), 32'd0);
        checkVal("rstOwner", 32'(owner), 32'd0);
        checkVal("rstValid", 32'(bus_valid), 32'd0);
        checkVal("rstBus", 32'(bus_out), 32'd0);
        checkVal("rstPreempt", 32'(preempt), 32'd0);
        tick(1);
        reset = 1'b0;

        // Reset while requester 1 owns the Bus
        applyStimulus(4'b0010);
        tick(1);
        checkVal("aGrant", 32'(grant), 32'h2);
        checkVal("aOwner", 32'(owner), 32'd1);
        tick(1);
        reset = 1'b1;
        #1;
        checkVal("aRstGrant", 32'(grant), 32'd0);
        checkVal("aRstValid", 32'(bus_valid), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        checkVal("aRegrant", 32'(grant), 32'h2);
        checkVal("aRegrantOwner", 32'(owner), 32'd1);
        applyStimulus(4'b0000);
        tick(2);

        // Lone requester keeps the Bus with no preemption
        applyStimulus(4'b0001);
        tick(1);
        checkVal("bGrant", 32'(grant), 32'h1);
        checkVal("bBus", 32'(bus_out), 32'hBEEF);
        tick(19);
        checkVal("bGrantHeld", 32'(grant), 32'h1);
        checkVal("bPreempt", 32'(preempt), 32'd0);

        // Release with requester 2 waiting: one dead cycle then handover
        applyStimulus(4'b0100);
        tick(1);
        checkVal("cTurnGrant", 32'(grant), 32'd0);
        checkVal("cTurnValid", 32'(bus_valid), 32'd0);
        tick(1);
        checkVal("cGrant", 32'(grant), 32'h4);
        checkVal("cBus", 32'(bus_out), 32'hCAFE);
        checkVal("cOwner", 32'(owner), 32'd2);
        applyStimulus(4'b0000);
        tick(2);

        // Everyone requesting, each owner releasing after one cycle
        resetPulse();
        applyStimulus(4'b1111);
        tick(1);
        for (int k = 0; k < 5; k++) begin
            checkVal("dRrGrant", 32'(grant), 32'(rrSeq[k]));
            applyStimulus(4'b1111 & ~rrSeq[k]);
            tick(1);
            checkVal("dRrTurn", 32'(grant), 32'd0);
            applyStimulus(4'b1111);
            tick(1);
        end
        applyStimulus(4'b0000);
        tick(2);

        // Two requesters trading the Bus by hold timeout
        resetPulse();
        applyStimulus(4'b0011);
        for (int k = 0; k < 11; k++) begin
            tick(1);
            checkVal("ePreGrant", 32'(grant), 32'(preGrant[k]));
            checkVal("ePrePulse", 32'(preempt), 32'(prePulse[k]));
        end

        // Owner 0 reaches its hold limit and releases on the same edge
        tick(3);
        applyStimulus(4'b0110);
        tick(1);
        checkVal("fTurnGrant", 32'(grant), 32'd0);
        checkVal("fTurnPreempt", 32'(preempt), 32'd0);
        tick(1);
        checkVal("fGrant", 32'(grant), 32'h2);
        checkVal("fOwner", 32'(owner), 32'd1);
        applyStimulus(4'b0000);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
